// File: rtl/fetch_decode.sv
// Single-beat Wishbone pipelined bus master with an optional instruction
// decoder on completed reads. One request in flight; requests arriving while
// busy are dropped. Decoded fields appear one cycle after the read completes.
module fetch_decode #(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_enable,
    input  logic [DW-1:0] i_addr,
    input  logic          i_we,
    input  logic [DW-1:0] i_value,
    input  logic          i_decode,
    output logic [DW-1:0] o_data,
    output logic          o_completed,
    output logic          o_wb_cyc,
    output logic          o_wb_stb,
    output logic          o_wb_we,
    output logic [DW-1:0] o_wb_addr,
    output logic [DW-1:0] o_wb_data,
    input  logic          i_wb_ack,
    input  logic          i_wb_stall,
    input  logic [DW-1:0] i_wb_data,
    output logic [3:0]    o_opcode,
    output logic [3:0]    o_extra,
    output logic [3:0]    o_operandA,
    output logic [3:0]    o_operandB,
    output logic [15:0]   o_immediate,
    output logic          o_dec_completed
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [DW-1:0] addr_q, addr_d;
    logic [DW-1:0] value_q, value_d;
    logic          we_q, we_d;
    logic          decode_q, decode_d;
    logic [DW-1:0] data_q, data_d;
    logic [DW-1:0] fields_q, fields_d;
    logic          completed_q, completed_d;
    logic          dec_go_q, dec_go_d;
    logic          dec_completed_q, dec_completed_d;
    logic          ack_ok;

    // An ack only counts once the strobe has been accepted (or in the same
    // cycle it is accepted); acks while idle or stalled are ignored.
    assign ack_ok = ((state_q == REQ) && !i_wb_stall && i_wb_ack) ||
                    ((state_q == WAIT) && i_wb_ack);

    // Next-state, request latching, completion and decode logic
    always_comb begin
        state_d         = state_q;
        addr_d          = addr_q;
        value_d         = value_q;
        we_d            = we_q;
        decode_d        = decode_q;
        data_d          = data_q;
        fields_d        = fields_q;
        completed_d     = 1'b0;
        dec_go_d        = 1'b0;
        dec_completed_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (i_enable) begin
                    state_d  = REQ;
                    addr_d   = i_addr;
                    value_d  = i_value;
                    we_d     = i_we;
                    decode_d = i_decode;
                end
            end
            REQ: begin
                if (!i_wb_stall) begin
                    state_d = i_wb_ack ? IDLE : WAIT;
                end
            end
            WAIT: begin
                if (i_wb_ack) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (ack_ok) begin
            completed_d = 1'b1;
            if (!we_q) begin
                data_d   = i_wb_data;
                dec_go_d = decode_q;
            end
        end

        // data_q still holds the read word here: no second ack can land
        // within one cycle of a completion.
        if (dec_go_q) begin
            fields_d        = data_q;
            dec_completed_d = 1'b1;
        end
    end

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q         <= IDLE;
            addr_q          <= '0;
            value_q         <= '0;
            we_q            <= 1'b0;
            decode_q        <= 1'b0;
            data_q          <= '0;
            fields_q        <= '0;
            completed_q     <= 1'b0;
            dec_go_q        <= 1'b0;
            dec_completed_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            addr_q          <= addr_d;
            value_q         <= value_d;
            we_q            <= we_d;
            decode_q        <= decode_d;
            data_q          <= data_d;
            fields_q        <= fields_d;
            completed_q     <= completed_d;
            dec_go_q        <= dec_go_d;
            dec_completed_q <= dec_completed_d;
        end
    end

    assign o_wb_cyc        = (state_q != IDLE);
    assign o_wb_stb        = (state_q == REQ);
    assign o_wb_we         = o_wb_cyc && we_q;
    assign o_wb_addr       = addr_q;
    assign o_wb_data       = value_q;
    assign o_data          = data_q;
    assign o_completed     = completed_q;
    assign o_dec_completed = dec_completed_q;
    assign o_opcode        = fields_q[31:28];
    assign o_extra         = fields_q[27:24];
    assign o_operandA      = fields_q[23:20];
    assign o_operandB      = fields_q[19:16];
    assign o_immediate     = fields_q[15:0];

endmodule

// File: tb/tb_fetch_decode.sv
// Bench for fetch_decode: a directed vector table, randomized transactions
// checked against a transaction-level model, and reset corner sequences.
module tb_fetch_decode;

    logic        clk;
    logic        reset;
    logic        i_enable;
    logic [31:0] i_addr;
    logic        i_we;
    logic [31:0] i_value;
    logic        i_decode;
    logic [31:0] o_data;
    logic        o_completed;
    logic        o_wb_cyc;
    logic        o_wb_stb;
    logic        o_wb_we;
    logic [31:0] o_wb_addr;
    logic [31:0] o_wb_data;
    logic        i_wb_ack;
    logic        i_wb_stall;
    logic [31:0] i_wb_data;
    logic [3:0]  o_opcode;
    logic [3:0]  o_extra;
    logic [3:0]  o_operandA;
    logic [3:0]  o_operandB;
    logic [15:0] o_immediate;
    logic        o_dec_completed;

    fetch_decode #(.DW(32)) dut (
        .clk(clk), .reset(reset), .i_enable(i_enable), .i_addr(i_addr),
        .i_we(i_we), .i_value(i_value), .i_decode(i_decode), .o_data(o_data),
        .o_completed(o_completed), .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb),
        .o_wb_we(o_wb_we), .o_wb_addr(o_wb_addr), .o_wb_data(o_wb_data),
        .i_wb_ack(i_wb_ack), .i_wb_stall(i_wb_stall), .i_wb_data(i_wb_data),
        .o_opcode(o_opcode), .o_extra(o_extra), .o_operandA(o_operandA),
        .o_operandB(o_operandB), .o_immediate(o_immediate),
        .o_dec_completed(o_dec_completed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        bit          we;
        logic [31:0] addr;
        logic [31:0] value;
        bit          dec;
        int          stall;
        int          wait_n;
        logic [31:0] rdata;
        bit          stray;
        bit          poke;
        bit          b2b;
        logic [31:0] exp_data;
        bit          exp_dec;
        logic [31:0] exp_word;
    } vec_t;

    int n_tests = 0;
    int n_fail  = 0;

    // Transaction-level model: last read word, the word the decoder holds,
    // and a decode that becomes visible at the next edge.
    logic [31:0] model_data;
    logic [31:0] model_word;
    bit          dec_due;
    logic [31:0] due_word;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_fields(input string tag, input logic [31:0] w);
        chk({tag, ".opcode"},  32'(o_opcode),    (w >> 28) & 32'hF);
        chk({tag, ".extra"},   32'(o_extra),     (w >> 24) & 32'hF);
        chk({tag, ".opA"},     32'(o_operandA),  (w >> 20) & 32'hF);
        chk({tag, ".opB"},     32'(o_operandB),  (w >> 16) & 32'hF);
        chk({tag, ".imm"},     32'(o_immediate), w & 32'hFFFF);
    endtask

    // Advance one edge and check the outputs the model tracks every cycle.
    task automatic step();
        bit pulse;
        @(posedge clk);
        #1;
        pulse = dec_due;
        if (dec_due) model_word = due_word;
        dec_due = 1'b0;
        chk("dec_completed", 32'(o_dec_completed), 32'(pulse));
        chk("o_data", o_data, model_data);
        chk_fields("fields", model_word);
    endtask

    task automatic bus_chk(input string tag, input bit stb, input bit we,
                           input logic [31:0] addr, input logic [31:0] value);
        chk({tag, ".cyc"},       32'(o_wb_cyc),    32'd1);
        chk({tag, ".stb"},       32'(o_wb_stb),    32'(stb));
        chk({tag, ".we"},        32'(o_wb_we),     32'(we));
        chk({tag, ".addr"},      o_wb_addr,        addr);
        chk({tag, ".wdata"},     o_wb_data,        value);
        chk({tag, ".completed"}, 32'(o_completed), 32'd0);
    endtask

    task automatic drive_poke(input bit poke);
        i_enable = poke;
        if (poke) begin
            i_addr   = $urandom;
            i_we     = 1'($urandom);
            i_value  = $urandom;
            i_decode = 1'($urandom);
        end
    endtask

    task automatic step_idle();
        i_enable   = 1'b0;
        i_wb_ack   = 1'($urandom);
        i_wb_stall = 1'($urandom);
        i_wb_data  = $urandom;
        step();
        chk("idle.cyc",       32'(o_wb_cyc),    32'd0);
        chk("idle.stb",       32'(o_wb_stb),    32'd0);
        chk("idle.we",        32'(o_wb_we),     32'd0);
        chk("idle.completed", 32'(o_completed), 32'd0);
        i_wb_ack = 1'b0;
    endtask

    // One full transfer starting from IDLE (or from a completion cycle).
    task automatic run_txn(input bit we, input logic [31:0] addr, input logic [31:0] value,
                           input bit dec, input int stall, input int wait_n,
                           input logic [31:0] rdata, input bit stray, input bit poke);
        i_enable   = 1'b1;
        i_addr     = addr;
        i_we       = we;
        i_value    = value;
        i_decode   = dec;
        i_wb_ack   = 1'b0;
        i_wb_stall = 1'b0;
        step();
        bus_chk("req", 1'b1, we, addr, value);
        for (int s = 0; s < stall; s++) begin
            drive_poke(poke);
            i_wb_stall = 1'b1;
            i_wb_ack   = stray;
            i_wb_data  = $urandom;
            step();
            bus_chk("stall", 1'b1, we, addr, value);
        end
        i_wb_stall = 1'b0;
        drive_poke(poke);
        if (wait_n > 0) begin
            i_wb_ack = 1'b0;
            step();
            bus_chk("wait", 1'b0, we, addr, value);
            for (int k = 1; k < wait_n; k++) begin
                drive_poke(poke);
                step();
                bus_chk("wait", 1'b0, we, addr, value);
            end
        end
        i_wb_ack  = 1'b1;
        i_wb_data = rdata;
        if (!we) model_data = rdata;
        step();
        chk("done.completed", 32'(o_completed), 32'd1);
        chk("done.cyc",       32'(o_wb_cyc),    32'd0);
        chk("done.stb",       32'(o_wb_stb),    32'd0);
        chk("done.we",        32'(o_wb_we),     32'd0);
        if (!we && dec) begin
            dec_due  = 1'b1;
            due_word = rdata;
        end
        i_wb_ack  = 1'b0;
        i_enable  = 1'b0;
        i_wb_data = $urandom;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".cyc"},       32'(o_wb_cyc),        32'd0);
        chk({tag, ".stb"},       32'(o_wb_stb),        32'd0);
        chk({tag, ".we"},        32'(o_wb_we),         32'd0);
        chk({tag, ".completed"}, 32'(o_completed),     32'd0);
        chk({tag, ".dec"},       32'(o_dec_completed), 32'd0);
        chk({tag, ".data"},      o_data,               32'd0);
        chk({tag, ".addr"},      o_wb_addr,            32'd0);
        chk({tag, ".wdata"},     o_wb_data,            32'd0);
        chk_fields(tag, 32'd0);
    endtask

    vec_t tbl[7];

    initial begin
        tbl[0] = '{1'b0, 32'hb0000000, 32'h0,        1'b1, 0, 0, 32'h4A9B1234, 1'b0, 1'b0, 1'b0, 32'h4A9B1234, 1'b1, 32'h4A9B1234};
        tbl[1] = '{1'b1, 32'hb000fffc, 32'hDEADBEEF, 1'b1, 0, 1, 32'h55555555, 1'b0, 1'b0, 1'b0, 32'h4A9B1234, 1'b0, 32'h4A9B1234};
        tbl[2] = '{1'b0, 32'h00001000, 32'h0,        1'b1, 3, 2, 32'h12345678, 1'b0, 1'b0, 1'b0, 32'h12345678, 1'b1, 32'h12345678};
        tbl[3] = '{1'b0, 32'h00002004, 32'h0,        1'b0, 0, 3, 32'h0F0F0F0F, 1'b0, 1'b1, 1'b0, 32'h0F0F0F0F, 1'b0, 32'h12345678};
        tbl[4] = '{1'b0, 32'h00003008, 32'h0,        1'b1, 2, 0, 32'h89ABCDEF, 1'b1, 1'b1, 1'b1, 32'h89ABCDEF, 1'b1, 32'h89ABCDEF};
        tbl[5] = '{1'b1, 32'h0000400c, 32'h11112222, 1'b0, 1, 1, 32'h77777777, 1'b0, 1'b0, 1'b1, 32'h89ABCDEF, 1'b0, 32'h89ABCDEF};
        tbl[6] = '{1'b0, 32'h00005010, 32'h0,        1'b1, 0, 0, 32'hFEDCBA98, 1'b0, 1'b0, 1'b0, 32'hFEDCBA98, 1'b1, 32'hFEDCBA98};

        model_data = 32'd0;
        model_word = 32'd0;
        dec_due    = 1'b0;
        due_word   = 32'd0;

        // Reset, with a request presented during it that must be dropped
        reset      = 1'b0;
        i_enable   = 1'b1;
        i_addr     = 32'h12345678;
        i_we       = 1'b1;
        i_value    = 32'hCAFEF00D;
        i_decode   = 1'b1;
        i_wb_ack   = 1'b0;
        i_wb_stall = 1'b0;
        i_wb_data  = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("reset");
        reset    = 1'b1;
        i_enable = 1'b0;
        step_idle();
        step_idle();

        // Directed vector table
        for (int i = 0; i < 7; i++) begin
            run_txn(tbl[i].we, tbl[i].addr, tbl[i].value, tbl[i].dec, tbl[i].stall,
                    tbl[i].wait_n, tbl[i].rdata, tbl[i].stray, tbl[i].poke);
            chk($sformatf("vec%0d.data", i), o_data, tbl[i].exp_data);
            if (!tbl[i].b2b) begin
                step_idle();
                chk($sformatf("vec%0d.dec", i), 32'(o_dec_completed), 32'(tbl[i].exp_dec));
                chk_fields($sformatf("vec%0d", i), tbl[i].exp_word);
            end
        end

        // Randomized transactions against the model
        for (int i = 0; i < 200; i++) begin
            bit b2b;
            b2b = 1'($urandom);
            run_txn(1'($urandom), $urandom, $urandom, 1'($urandom),
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                    $urandom, 1'($urandom), 1'($urandom));
            if (!b2b) step_idle();
        end
        step_idle();
        step_idle();

        // Reset in the middle of a transfer, then a late ack
        i_enable   = 1'b1;
        i_addr     = 32'hA5A5A5A0;
        i_we       = 1'b0;
        i_value    = 32'h0;
        i_decode   = 1'b1;
        i_wb_stall = 1'b0;
        i_wb_ack   = 1'b0;
        step();
        bus_chk("rst_req", 1'b1, 1'b0, 32'hA5A5A5A0, 32'h0);
        i_enable = 1'b0;
        step();
        bus_chk("rst_wait", 1'b0, 1'b0, 32'hA5A5A5A0, 32'h0);
        reset    = 1'b0;
        i_enable = 1'b1;
        @(posedge clk);
        #1;
        chk_all_zero("midreset");
        model_data = 32'd0;
        model_word = 32'd0;
        dec_due    = 1'b0;
        reset      = 1'b1;
        i_enable   = 1'b0;
        i_wb_ack   = 1'b1;
        i_wb_data  = 32'h13572468;
        step();
        chk("late_ack.cyc",       32'(o_wb_cyc),    32'd0);
        chk("late_ack.completed", 32'(o_completed), 32'd0);
        i_wb_ack = 1'b0;
        step();
        chk("post_ack.completed", 32'(o_completed), 32'd0);
        chk("post_ack.cyc",       32'(o_wb_cyc),    32'd0);

        // Recovery: a normal read after the aborted transfer
        run_txn(1'b0, 32'h00000040, 32'h0, 1'b1, 0, 1, 32'h0BADF00D, 1'b0, 1'b0);
        step_idle();
        chk("recover.dec", 32'(o_dec_completed), 32'd1);
        chk_fields("recover", 32'h0BADF00D);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
